// File: rtl/demux_burst_sched_if.sv
// Handshake bundle for demux_burst_sched: input stream, four-way one-hot output,
// channel enables and scheduler status.
interface demux_burst_sched_if #(
    parameter int WIDTH = 8
);
    logic [3:0]       en;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [1:0]       sel;
    logic             busy;

    modport slave (
        input  en, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, sel, busy
    );

    modport master (
        output en, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, sel, busy
    );
endinterface

// File: rtl/demux_burst_sched.sv
// Burst-interleaving 1-to-4 demux scheduler with a one-entry output buffer.
// Optional DEMUX_SCHED_SKIP_EN: burst rotation also skips channels whose sink is not ready.
module demux_burst_sched #(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input logic               clk,
    input logic               rst_n,
    demux_burst_sched_if.slave bus
);
    localparam int            CW    = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] CLAST = CW'(BURST - 1);

    // First set bit of m after p, searching p+1, p+2, p+3, then p itself.
    function automatic logic [1:0] next_ch(input logic [1:0] p, input logic [3:0] m);
        logic [1:0] r;
        r = p;
        for (int k = 3; k >= 1; k--) begin
            if (m[p + 2'(k)]) r = p + 2'(k);
        end
        return r;
    endfunction

    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       tag_q, tag_d;
    logic             full_q, full_d;
    logic [1:0]       sel_q, sel_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic       drain, in_rdy, accept;
    logic [1:0] dst, rot_nxt;
`ifdef DEMUX_SCHED_SKIP_EN
    logic [3:0] qual;
`endif

    always_comb begin
        drain   = full_q && bus.out_ready[tag_q];
        in_rdy  = rst_n && (bus.en != 4'b0) && (!full_q || drain);
        accept  = bus.in_valid && in_rdy;
        dst     = bus.en[sel_q] ? sel_q : next_ch(sel_q, bus.en);
        // Both rotation cases advance from dst (equal to sel when the pointer is enabled).
        rot_nxt = next_ch(dst, bus.en);
`ifdef DEMUX_SCHED_SKIP_EN
        qual = bus.en & bus.out_ready & ~(4'b0001 << dst);
        if (qual != 4'b0) rot_nxt = next_ch(dst, qual);
`endif
    end

    always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        full_d = full_q;
        sel_d  = sel_q;
        cnt_d  = cnt_q;
        if (accept) begin
            data_d = bus.in_data;
            tag_d  = dst;
            full_d = 1'b1;
            if (dst != sel_q) begin
                cnt_d = (BURST > 1) ? CW'(1) : '0;
                sel_d = (BURST == 1) ? rot_nxt : dst;
            end else if (cnt_q == CLAST) begin
                cnt_d = '0;
                sel_d = rot_nxt;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            tag_q  <= '0;
            full_q <= 1'b0;
            sel_q  <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            tag_q  <= tag_d;
            full_q <= full_d;
            sel_q  <= sel_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_data  = data_q;
    assign bus.out_valid = full_q ? (4'b0001 << tag_q) : 4'b0000;
    assign bus.sel       = sel_q;
    assign bus.busy      = full_q;
endmodule

// File: tb/tb_demux_burst_sched.sv
// Self-checking bench for demux_burst_sched: directed scenarios plus a randomized
// run against a beat-level reference model.
module tb_demux_burst_sched;
    localparam int WIDTH = 8;
    localparam int BURST = 4;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    demux_burst_sched_if #(.WIDTH(WIDTH)) bus ();

    demux_burst_sched #(.WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: what sits in the buffer and where the next burst points.
    bit         m_full;
    int         m_tag, m_sel, m_cnt;
    logic [7:0] m_data;

    function automatic int first_after(input int p, input logic [3:0] m);
        for (int k = 1; k <= 4; k++)
            if (m[(p + k) % 4]) return (p + k) % 4;
        return p;
    endfunction

    function automatic int rotate_from(input int p);
`ifdef DEMUX_SCHED_SKIP_EN
        for (int k = 1; k <= 3; k++)
            if (bus.en[(p + k) % 4] && bus.out_ready[(p + k) % 4]) return (p + k) % 4;
`endif
        return first_after(p, bus.en);
    endfunction

    function automatic bit model_ready();
        return (bus.en != 0) && (!m_full || bus.out_ready[m_tag]);
    endfunction

    function automatic logic [3:0] model_valid();
        return m_full ? 4'(1 << m_tag) : 4'b0000;
    endfunction

    task automatic model_reset();
        m_full = 0; m_tag = 0; m_sel = 0; m_cnt = 0; m_data = '0;
    endtask

    task automatic model_step();
        int  dst;
        bit  drain;
        drain = m_full && bus.out_ready[m_tag];
        if (bus.in_valid && model_ready()) begin
            dst    = bus.en[m_sel] ? m_sel : first_after(m_sel, bus.en);
            m_data = bus.in_data;
            m_full = 1;
            if (dst != m_sel) begin
                m_cnt = (BURST > 1) ? 1 : 0;
                m_sel = (BURST == 1) ? rotate_from(dst) : dst;
            end else if (m_cnt == BURST - 1) begin
                m_cnt = 0;
                m_sel = rotate_from(m_sel);
            end else begin
                m_cnt++;
            end
            m_tag = dst;
        end else if (drain) begin
            m_full = 0;
        end
    endtask

    task automatic drive(input logic [3:0] e, input logic v, input logic [7:0] d, input logic [3:0] r);
        bus.en = e; bus.in_valid = v; bus.in_data = d; bus.out_ready = r;
        #1;
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        drive(4'b0000, 1'b0, 8'h00, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        drive(4'b1111, 1'b1, 8'hAA, 4'b1111);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 4'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0000", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.sel !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", bus.sel); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Beat k of 16 belongs to channel k/4; each beat shows the cycle after its accept.
    task automatic test_rotation();
        for (int k = 0; k < 16; k++) begin
            drive(4'b1111, 1'b1, 8'(k), 4'b1111);
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rot_in_ready k=%0d got=%b exp=1", k, bus.in_ready); end
            checks++; if (bus.sel !== 2'((k / 4) % 4)) begin errors++; $display("FAIL rot_sel k=%0d got=%0d exp=%0d", k, bus.sel, (k / 4) % 4); end
            if (k > 0) begin
                checks++; if (bus.out_valid !== 4'(1 << ((k - 1) / 4))) begin errors++; $display("FAIL rot_valid k=%0d got=%b exp=%b", k, bus.out_valid, 4'(1 << ((k - 1) / 4))); end
                checks++; if (bus.out_data !== 8'(k - 1)) begin errors++; $display("FAIL rot_data k=%0d got=%h exp=%h", k, bus.out_data, 8'(k - 1)); end
            end
            tick();
        end
        drive(4'b1111, 1'b0, 8'h00, 4'b1111);
        checks++; if (bus.out_valid !== 4'b1000 || bus.out_data !== 8'h0F) begin errors++; $display("FAIL rot_last got=%b/%h exp=1000/0f", bus.out_valid, bus.out_data); end
        checks++; if (bus.sel !== 2'd0) begin errors++; $display("FAIL rot_wrap_sel got=%0d exp=0", bus.sel); end
        tick();
        drive(4'b1111, 1'b0, 8'h00, 4'b1111);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rot_idle_busy got=%b exp=0", bus.busy); end
        tick();
    endtask

    task automatic test_sparse_en();
        apply_reset();
        for (int k = 0; k <= 8; k++) begin
            drive(4'b0101, k < 8, 8'(8'h20 + k), 4'b1111);
            if (k > 0) begin
                checks++; if (bus.out_valid !== ((k - 1) < 4 ? 4'b0001 : 4'b0100)) begin errors++; $display("FAIL sparse_valid k=%0d got=%b", k, bus.out_valid); end
                checks++; if (bus.out_data !== 8'(8'h20 + k - 1)) begin errors++; $display("FAIL sparse_data k=%0d got=%h exp=%h", k, bus.out_data, 8'(8'h20 + k - 1)); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int k = 0; k < 4; k++) begin drive(4'b1111, 1'b1, 8'(k), 4'b1111); tick(); end
        drive(4'b1111, 1'b1, 8'h42, 4'b1111);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 1'b1, 8'h43, 4'b1101);
            checks++; if (bus.out_valid !== 4'b0010 || bus.out_data !== 8'h42) begin errors++; $display("FAIL bp_hold i=%0d got=%b/%h exp=0010/42", i, bus.out_valid, bus.out_data); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready i=%0d got=%b exp=0", i, bus.in_ready); end
            tick();
        end
        drive(4'b1111, 1'b1, 8'h43, 4'b1111);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%b exp=1", bus.in_ready); end
        tick();
        drive(4'b1111, 1'b0, 8'h00, 4'b1111);
        checks++; if (bus.out_valid !== 4'b0010 || bus.out_data !== 8'h43) begin errors++; $display("FAIL bp_resume got=%b/%h exp=0010/43", bus.out_valid, bus.out_data); end
        tick();
    endtask

    task automatic test_en_change();
        apply_reset();
        drive(4'b1111, 1'b1, 8'h50, 4'b1111); tick();
        drive(4'b1111, 1'b1, 8'h51, 4'b1111); tick();
        drive(4'b1110, 1'b0, 8'h00, 4'b1110);
        checks++; if (bus.out_valid !== 4'b0001 || bus.out_data !== 8'h51) begin errors++; $display("FAIL enc_keep got=%b/%h exp=0001/51", bus.out_valid, bus.out_data); end
        tick();
        drive(4'b1110, 1'b1, 8'h52, 4'b1111);
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 4'b0001) begin errors++; $display("FAIL enc_drain got=%b/%b exp=1/0001", bus.in_ready, bus.out_valid); end
        tick();
        // 0x52 opens channel 1 with one beat already counted, so 0x52..0x55 fill it.
        for (int k = 0; k < 4; k++) begin
            drive(4'b1110, 1'b1, 8'(8'h53 + k), 4'b1111);
            checks++; if (bus.out_valid !== 4'b0010 || bus.out_data !== 8'(8'h52 + k)) begin errors++; $display("FAIL enc_ch1 k=%0d got=%b/%h exp=0010/%h", k, bus.out_valid, bus.out_data, 8'(8'h52 + k)); end
            tick();
        end
        drive(4'b1110, 1'b0, 8'h00, 4'b1111);
        checks++; if (bus.out_valid !== 4'b0100 || bus.out_data !== 8'h56) begin errors++; $display("FAIL enc_ch2 got=%b/%h exp=0100/56", bus.out_valid, bus.out_data); end
        tick();
    endtask

    task automatic test_en_zero_and_reset();
        apply_reset();
        drive(4'b1111, 1'b1, 8'h60, 4'b0000); tick();
        for (int i = 0; i < 2; i++) begin
            drive(4'b0000, 1'b1, 8'h61, 4'b0000);
            checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 4'b0001) begin errors++; $display("FAIL enz_hold i=%0d got=%b/%b exp=0/0001", i, bus.in_ready, bus.out_valid); end
            tick();
        end
        drive(4'b0000, 1'b1, 8'h61, 4'b1111);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL enz_ready got=%b exp=0", bus.in_ready); end
        tick();
        drive(4'b0000, 1'b1, 8'h61, 4'b1111);
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 4'b0000 || bus.sel !== 2'd0) begin errors++; $display("FAIL enz_drained got=%b/%b/%0d exp=0/0000/0", bus.busy, bus.out_valid, bus.sel); end
        tick();
        drive(4'b1111, 1'b1, 8'h61, 4'b1111); tick();
        drive(4'b1111, 1'b0, 8'h00, 4'b0000); tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.out_valid !== 4'b0000 || bus.sel !== 2'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL midrst got=%b/%0d/%b exp=0000/0/0", bus.out_valid, bus.sel, bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            drive(4'b1111, 1'b1, 8'(8'h70 + k), 4'b1111);
            if (k > 0) begin
                checks++; if (bus.out_valid !== 4'b0001 || bus.out_data !== 8'(8'h70 + k - 1)) begin errors++; $display("FAIL postrst k=%0d got=%b/%h", k, bus.out_valid, bus.out_data); end
            end
            tick();
        end
        drive(4'b1111, 1'b0, 8'h00, 4'b1111);
        checks++; if (bus.out_valid !== 4'b0010 || bus.out_data !== 8'h74) begin errors++; $display("FAIL postrst_ch1 got=%b/%h exp=0010/74", bus.out_valid, bus.out_data); end
        tick();
    endtask

    task automatic test_skip();
        logic [1:0] exp_sel;
        logic [3:0] exp_vld;
        logic       exp_rdy;
`ifdef DEMUX_SCHED_SKIP_EN
        exp_sel = 2'd2; exp_vld = 4'b0100; exp_rdy = 1'b1;
`else
        exp_sel = 2'd1; exp_vld = 4'b0010; exp_rdy = 1'b0;
`endif
        apply_reset();
        for (int k = 0; k < 3; k++) begin drive(4'b1111, 1'b1, 8'(k), 4'b1111); tick(); end
        drive(4'b1111, 1'b1, 8'h03, 4'b1101); tick();
        drive(4'b1111, 1'b1, 8'h04, 4'b1101);
        checks++; if (bus.sel !== exp_sel) begin errors++; $display("FAIL skip_sel got=%0d exp=%0d", bus.sel, exp_sel); end
        tick();
        drive(4'b1111, 1'b0, 8'h00, 4'b1101);
        checks++; if (bus.out_valid !== exp_vld || bus.out_data !== 8'h04) begin errors++; $display("FAIL skip_dest got=%b/%h exp=%b/04", bus.out_valid, bus.out_data, exp_vld); end
        checks++; if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL skip_ready got=%b exp=%b", bus.in_ready, exp_rdy); end
        tick();
    endtask

    task automatic test_random();
        logic [3:0] e, r;
        logic [7:0] d;
        logic       v;
        apply_reset();
        e = 4'b1111;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 19) == 0) e = 4'($urandom_range(0, 15));
            v = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 3) != 0);
            drive(e, v, d, r);
            checks++; if (bus.in_ready !== model_ready()) begin errors++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, bus.in_ready, model_ready()); end
            checks++; if (bus.out_valid !== model_valid()) begin errors++; $display("FAIL rnd_out_valid c=%0d got=%b exp=%b", c, bus.out_valid, model_valid()); end
            checks++; if (bus.out_data !== m_data) begin errors++; $display("FAIL rnd_out_data c=%0d got=%h exp=%h", c, bus.out_data, m_data); end
            checks++; if (bus.sel !== 2'(m_sel) || bus.busy !== m_full) begin errors++; $display("FAIL rnd_sel_busy c=%0d got=%0d/%b exp=%0d/%b", c, bus.sel, bus.busy, m_sel, m_full); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_sparse_en();
        test_backpressure();
        test_en_change();
        test_en_zero_and_reset();
        test_skip();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/demux_burst_sched.md
# demux_burst_sched

Burst-interleaving scheduler for the 1-to-4 demultiplexer datapath. Accepts a single valid/ready input stream, stores each beat in a one-entry output register, and routes it to one of four channels A..D (index 0..3), rotating through the enabled channels in fixed bursts of `BURST` beats. The block owns the select encoding (`sel[1]`=s1, `sel[0]`=s2) and drives one-hot per-channel valids, so downstream logic never sees an undriven or stale channel.

## Interface
- `WIDTH`, 8, data width in bits (1..64)
- `BURST`, 4, beats per channel before rotating (1..256)

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `en`  in  4  per-channel enable mask; bit i = channel i
- `in_data`  in  WIDTH  input beat
- `in_valid`  in  1  input beat present
- `in_ready`  out  1  input beat accepted this cycle when `in_valid && in_ready`
- `out_data`  out  WIDTH  buffered beat, shared by all channels
- `out_valid`  out  4  one-hot; bit i = buffered beat destined for channel i
- `out_ready`  in  4  per-channel sink ready
- `sel`  out  2  channel pointer for the next accepted beat
- `busy`  out  1  buffer holds an undelivered beat

## Operation
- Registers: buffer `out_data`, tag `tag[1:0]`, `full`, pointer `sel`, beat counter `cnt` (width clog2(BURST), min 1).
- `out_valid[i] = full && (tag == i)`; `busy = full`.
- Drain: `drain = full && out_ready[tag]`.
- `in_ready = (en != 0) && (!full || drain)` (combinational through `out_ready`).
- Destination on accept: `dst = en[sel] ? sel : next_en(sel)`, where `next_en(p)` = first enabled channel after p in order p+1, p+2, p+3, p (mod 4).
- On accept: `out_data <= in_data`, `tag <= dst`, `full <= 1`.
  - If `dst != sel` (pointer channel disabled): `cnt <= 1` if BURST>1 else 0; `sel <= (BURST==1) ? next_en(dst) : dst`.
  - Else if `cnt == BURST-1`: `cnt <= 0`, `sel <= next_en(sel)`; if only `sel` is enabled, `sel` stays.
  - Else `cnt <= cnt+1`.
- On drain without accept: `full <= 0`; `out_data` holds last value.
- Simultaneous drain and accept: buffer reloaded, `full` stays 1; full throughput.
- `en` change never retags a buffered beat; it is delivered to its original channel even if that channel is now disabled.
- `en == 0`: no accepts; `sel`, `cnt` frozen; buffered beat still drains.
- `in_valid` low: `sel`, `cnt` frozen (bursts count beats, not cycles).

## Timing
- Reset (async assert, synchronous effect on release edge): `out_valid=0`, `out_data=0`, `tag=0`, `full=0`, `busy=0`, `sel=0`, `cnt=0`, `in_ready=0` while `rst_n` low.
- Latency: beat accepted at edge N appears on `out_valid`/`out_data` after edge N; delivered at first edge where `out_ready[tag]` is high.
- Throughput: 1 beat/cycle while destination sink ready.
- Reset mid-burst discards the buffered beat; next burst starts at channel 0 with `cnt=0`.
- `sel` updates on the accept edge; valid for the following cycle's accept.

## Configuration
- `DEMUX_SCHED_SKIP_EN`: when defined, the burst-rotation advance (`cnt == BURST-1` and disabled-pointer cases) selects the first channel after the current one that is enabled AND has `out_ready` high in the accept cycle; if none qualifies, falls back to `next_en`. When undefined, rotation uses `en` only and ignores `out_ready`.

## Test plan
- Reset, `en=4'b1111`, BURST=4, continuous `in_valid`, all `out_ready=1`, data 0x00..0x0F -> 0x00–0x03 on channel 0, 0x04–0x07 on 1, 0x08–0x0B on 2, 0x0C–0x0F on 3, one beat/cycle, `sel` returns to 0.
- `en=4'b0101`, 8 beats -> 4 beats to channel 0, 4 to channel 2, channels 1/3 never valid.
- Channel 1 `out_ready=0` for 5 cycles while beat 0x42 tagged 1 -> `out_valid=4'b0010`, `out_data=0x42` held, `in_ready=0`; release -> delivered next edge, input resumes.
- Clear `en[0]` after 2 beats of channel-0 burst with beat buffered -> buffered beat still delivered to 0; next beat goes to channel 1 with `cnt=1`.
- `en=0` with beat buffered -> beat drains, `in_ready` stays 0, `sel`/`cnt` unchanged; `rst_n` pulse mid-burst -> `out_valid=0`, `sel=0` immediately.
- With `DEMUX_SCHED_SKIP_EN`, `en=4'b1111`, `out_ready[1]=0` at end of channel-0 burst -> next burst on channel 2; without macro -> channel 1 and stall.
